// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencer that fetches from instruction memory and hands words to decode
module fetch_controller #(
   parameter int          RD_WAIT   = 2,
   parameter int          MEM_BYTES = 40,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_instr,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;
   localparam logic [32:0] LIMIT = 33'(MEM_BYTES);
   localparam logic [31:0] WAIT0 = 32'(RD_WAIT - 1);
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] tgt, nxt;
   logic        tgt_oob, nxt_oob, start_oob;
   assign tgt       = redirect_target & ~32'd3;
   assign nxt       = pc_q + 32'd4;
   assign tgt_oob   = {1'b0, tgt} >= LIMIT;
   assign nxt_oob   = ({1'b0, pc_q} + 33'd4) >= LIMIT;
   assign start_oob = {1'b0, RESET_PC} >= LIMIT;
   // Next-state logic: redirect beats handshake and wait countdown while busy
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      mem_address_d = mem_address_q;
      cnt_d         = cnt_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               pc_d          = RESET_PC;
               mem_address_d = RESET_PC;
               cnt_d         = WAIT0;
               instr_valid_d = 1'b0;
               state_d       = start_oob ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (redirect) begin
               pc_d          = tgt;
               mem_address_d = tgt;
               cnt_d         = WAIT0;
               instr_valid_d = 1'b0;
               state_d       = tgt_oob ? S_DONE : S_FETCH;
            end else if (cnt_q != 32'd0) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               instr_d       = mem_instr;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d          = tgt;
               mem_address_d = tgt;
               cnt_d         = WAIT0;
               instr_valid_d = 1'b0;
               state_d       = tgt_oob ? S_DONE : S_FETCH;
            end else if (instr_ready) begin
               pc_d          = nxt;
               mem_address_d = nxt;
               cnt_d         = WAIT0;
               instr_valid_d = 1'b0;
               state_d       = nxt_oob ? S_DONE : S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         mem_address_q <= RESET_PC;
         cnt_q         <= 32'd0;
         instr_q       <= 32'd0;
         instr_pc_q    <= 32'd0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_address_q <= mem_address_d;
         cnt_q         <= cnt_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end
   assign mem_address = mem_address_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
   assign done        = state_q == S_DONE;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random checks of fetch_controller against a timeline model
module tb_fetch_controller;
   localparam int          RW = 2;
   localparam int          MB = 40;
   localparam logic [31:0] RP = 32'd0;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0, mem_address, mem_instr, instr, instr_pc;
   logic        instr_valid, busy, done;
   logic [31:0] mem [16];
   int vecs = 0, errs = 0;
   bit          m_run, m_done, m_valid;
   logic [31:0] m_pc, m_addr, m_word, m_wpc;
   int          m_left;
   fetch_controller #(.RD_WAIT(RW), .MEM_BYTES(MB), .RESET_PC(RP)) dut (
      .clk(clk), .reset(reset), .start(start), .mem_address(mem_address), .mem_instr(mem_instr),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_target(redirect_target), .busy(busy), .done(done));
   always #5 clk = ~clk;
   assign mem_instr = mem[mem_address[5:2]];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic check_all();
      chk("mem_address", mem_address, m_addr);
      chk("instr", instr, m_word);
      chk("instr_pc", instr_pc, m_wpc);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
   endtask
   task automatic m_reset();
      m_run = 0; m_done = 0; m_valid = 0; m_pc = RP; m_addr = RP; m_word = 0; m_wpc = 0; m_left = 0;
   endtask
   // A fetch started at an edge delivers its word RW edges later; redirect restarts that clock.
   task automatic m_step(input bit s, input bit r, input bit rd, input logic [31:0] t);
      if (m_run) begin
         if (rd) begin
            m_pc = {t[31:2], 2'b00}; m_addr = m_pc; m_valid = 0;
            if (m_pc >= MB) begin m_run = 0; m_done = 1; end else m_left = RW;
         end else if (m_valid) begin
            if (r) begin
               m_valid = 0; m_pc = m_pc + 4; m_addr = m_pc;
               if (m_pc >= MB) begin m_run = 0; m_done = 1; end else m_left = RW;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin m_valid = 1; m_word = mem[m_pc / 4]; m_wpc = m_pc; end
         end
      end else if (s) begin
         m_pc = RP; m_addr = RP; m_done = 0;
         if (RP >= MB) m_done = 1; else begin m_run = 1; m_left = RW; end
      end
   endtask
   task automatic cyc(input bit s, input bit r, input bit rd, input logic [31:0] t);
      start = s; instr_ready = r; redirect = rd; redirect_target = t;
      m_step(s, r, rd, t);
      @(negedge clk);
      check_all();
   endtask
   task automatic run_to_valid(input logic [31:0] want, input string tag);
      int n = 0;
      while (!(m_valid && m_wpc == want) && n < 40) begin cyc(0, 1, 0, 0); n++; end
      chk(tag, instr_pc, want);
   endtask
   task automatic run_to_done();
      int n = 0;
      while (!m_done && n < 60) begin cyc(0, 1, 0, 0); n++; end
      chk("reach_done", 32'(done), 32'd1);
   endtask
   initial begin
      logic [31:0] w;
      int n;
      for (int i = 0; i < 16; i++) mem[i] = $urandom ^ (32'h1000_0000 * i);
      m_reset();
      @(negedge clk);
      check_all();
      reset = 1'b0;
      // basic fetch with ready high
      cyc(1, 1, 0, 0);
      run_to_done();
      chk("done_busy", 32'(busy), 32'd0);
      // backpressure at pc 8
      cyc(1, 1, 0, 0);
      run_to_valid(8, "bp_reach8");
      w = instr;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0);
         chk("bp_instr", instr, w);
         chk("bp_pc", instr_pc, 32'd8);
         chk("bp_addr", mem_address, 32'd8);
      end
      cyc(0, 1, 0, 0);
      run_to_valid(12, "bp_next12");
      run_to_done();
      // redirect mid-wait for pc 8
      cyc(1, 1, 0, 0);
      n = 0;
      while (!(m_run && !m_valid && m_pc == 8) && n < 40) begin cyc(0, 1, 0, 0); n++; end
      cyc(0, 1, 1, 32'h11);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("redir_valid", 32'(instr_valid), 32'd1);
      chk("redir_pc", instr_pc, 32'd16);
      run_to_done();
      // redirect coinciding with handshake at 12
      cyc(1, 1, 0, 0);
      run_to_valid(12, "rh_reach12");
      cyc(0, 1, 1, 32'd4);
      run_to_valid(4, "rh_target4");
      // out-of-range redirect, then restart
      cyc(0, 0, 1, 32'd40);
      chk("oob_done", 32'(done), 32'd1);
      for (int i = 0; i < 5; i++) cyc(0, 1'($urandom), 1'($urandom), $urandom_range(0, 47));
      cyc(1, 1, 0, 0);
      run_to_valid(0, "restart0");
      // asynchronous reset in the middle of a fetch
      cyc(0, 1, 0, 0);
      #2 reset = 1'b1;
      #1 m_reset();
      check_all();
      @(negedge clk);
      check_all();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, $urandom_range(0, 47));
      chk("idle_after_reset", 32'(busy), 32'd0);
      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 47));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
